window_feeder: RTL and testbench
================================

# window_feeder

Producer side of the multiply-reduce stream. It accepts a 1-D sample stream and holds a sliding window of NUM_ELEMENTS samples plus a bank of NUM_ELEMENTS kernel weights. Each time the window is due, it emits exactly NUM_ELEMENTS (sample, weight) pairs on a valid/ready interface. The output drives the dataa/datab/valid/ready inputs of the multiply-reduce block directly, so one burst produces one dot-product result downstream.

## Interface
- DATA_WIDTH, 12, width of samples and weights
- NUM_ELEMENTS, 5, kernel size (window length and beats per burst), >= 2
- STRIDE, 1, new samples required between bursts, 1..NUM_ELEMENTS
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- window_feeder_ready_in  out  1  sample accept; high in FILL and WAIT, low in STREAM
- window_feeder_valid_in  in  1  sample valid
- window_feeder_data_in  in  DATA_WIDTH  sample
- window_feeder_clr  in  1  synchronous window flush (weights kept)
- weight_wr_en  in  1  weight write strobe
- weight_wr_addr  in  clog2(NUM_ELEMENTS)  weight index
- weight_wr_data  in  DATA_WIDTH  weight value
- weight_wr_ready  out  1  high when state != STREAM
- window_feeder_ready_out  in  1  downstream ready
- window_feeder_valid_out  out  1  pair valid
- window_feeder_dataa_out  out  DATA_WIDTH  window sample
- window_feeder_datab_out  out  DATA_WIDTH  weight
- window_feeder_last_out  out  1  marks beat NUM_ELEMENTS-1 of a burst

## Operation
- States: FILL, WAIT, STREAM. Reset state is FILL.
- FILL: each accepted sample shifts into win[0], with older samples moving toward win[NUM_ELEMENTS-1], and increments fill_cnt. When the accept makes fill_cnt == NUM_ELEMENTS, go to STREAM with idx = 0.
- STREAM: ready_in = 0. Outputs are dataa = win[NUM_ELEMENTS-1-idx] (oldest first) and datab = weight[idx]. Each output handshake (valid_out && ready_out) increments idx. The handshake at idx == NUM_ELEMENTS-1 (last_out = 1) moves to WAIT and clears stride_cnt.
- WAIT: each accepted sample shifts in and increments stride_cnt. When the accept makes stride_cnt == STRIDE, go to STREAM with idx = 0.
- Weight write: accepted when weight_wr_en && weight_wr_ready. An address >= NUM_ELEMENTS is ignored. A write while in STREAM is dropped.
- clr: forces FILL and zeroes fill_cnt, stride_cnt, idx and valid_out; window contents are don't-care. If clr coincides with a sample accept or an output handshake, clr wins and the sample is discarded.
- No arithmetic on data. Counter widths: idx clog2(NUM_ELEMENTS), fill_cnt clog2(NUM_ELEMENTS+1), stride_cnt clog2(STRIDE+1).

## Timing
- Reset values: valid_out 0, last_out 0, dataa_out 0, datab_out 0, ready_in 1, weight_wr_ready 1. All weights and the window are reset to 0. Reset asserted mid-burst drops valid_out immediately and discards the partial burst and window.
- Outputs are registered. If the sample completing the window or stride is accepted at edge t, valid_out is high with beat 0 after edge t.
- While valid_out && !ready_out: dataa, datab and last are held stable. No beat is skipped or duplicated.
- With ready_out held high, one beat per cycle, so a burst occupies NUM_ELEMENTS cycles.
- After the last handshake, valid_out is 0 and ready_in is 1 on the following cycle. Minimum period is NUM_ELEMENTS + STRIDE cycles per burst.
- A weight write at edge t is visible to the next burst.

## Structure
- cnn1d_pkg:
  - add typedef enum window_feeder_state_t {FILL, WAIT, STREAM};
  - reuse the existing clog2.
- One sub-module, weight_bank: NUM_ELEMENTS x DATA_WIDTH register file with async reset, a write port, and a combinational read by idx.
- The window shift register, counters and FSM live in window_feeder.

## Test plan
All scenarios use NUM_ELEMENTS=5 and DATA_WIDTH=12; STRIDE=1 unless stated.
- Reset, then release: ready_in=1, valid_out=0, last_out=0, dataa/datab=0, weight_wr_ready=1.
- Weights 1,2,3,4,5; samples 10,20,30,40,50 -> beats (10,1),(20,2),(30,3),(40,4),(50,5), last only on the 5th beat; downstream multiply-reduce yields 550.
- Continue with sample 60 -> (20,1),(30,2),(40,3),(50,4),(60,5); result 700. Sample 60 is not accepted before the previous last handshake.
- ready_out low for 3 cycles while beat (20,2) is presented -> beat held unchanged, ready_in stays 0, sequence resumes with (30,3); exactly 5 beats total.
- STRIDE=2, samples 10..70 in steps of 10 -> bursts after 50 and after 70 only; 60 produces no burst. A weight write of 9 to address 0 during STREAM is dropped (weight_wr_ready=0).
- rst pulsed during beat 3 -> valid_out 0 immediately; 4 subsequent samples produce nothing, the 5th starts a fresh burst. clr asserted in WAIT behaves identically, and weights are retained.

Source files
------------

// File: rtl/cnn1d_pkg.sv
// Shared types and constant helpers for the 1-D CNN stream blocks.
package cnn1d_pkg;

  // Ceiling log2 with a floor of one bit so single-entry counters stay legal.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    while (int'(32'd1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    WAIT   = 2'd1,
    STREAM = 2'd2
  } window_feeder_state_t;

endpackage

// File: rtl/window_feeder_weight_bank.sv
// Kernel weight register file: one synchronous write port and a combinational
// read port; a write to the entry being read is forwarded straight through.
module weight_bank
  import cnn1d_pkg::*;
#(
  parameter int DATA_WIDTH   = 12,
  parameter int NUM_ELEMENTS = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [clog2(NUM_ELEMENTS)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic [clog2(NUM_ELEMENTS)-1:0] rd_idx,
  output logic [DATA_WIDTH-1:0]          rd_data
);

  localparam int ADDR_W = clog2(NUM_ELEMENTS);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(NUM_ELEMENTS);

  logic [DATA_WIDTH-1:0] mem_r [NUM_ELEMENTS];
  logic                  wr_ok_s;

  assign wr_ok_s = wr_en && ({1'b0, wr_addr} < DEPTH);

  // Weight storage; out-of-range addresses never reach the array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ELEMENTS; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (wr_ok_s) begin
      mem_r[wr_addr] <= wr_data;
    end else begin
      mem_r <= mem_r;
    end
  end

  // Read port with same-cycle write forwarding.
  always_comb begin
    if (wr_ok_s && (wr_addr == rd_idx)) begin
      rd_data = wr_data;
    end else if ({1'b0, rd_idx} < DEPTH) begin
      rd_data = mem_r[rd_idx];
    end else begin
      rd_data = {DATA_WIDTH{1'b0}};
    end
  end

endmodule

// File: rtl/window_feeder.sv
// Sliding-window producer: buffers NUM_ELEMENTS samples and streams
// (sample, weight) pairs, oldest sample first, one burst per window.
module window_feeder
  import cnn1d_pkg::*;
#(
  parameter int DATA_WIDTH   = 12,
  parameter int NUM_ELEMENTS = 5,
  parameter int STRIDE       = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic                           window_feeder_ready_in,
  input  logic                           window_feeder_valid_in,
  input  logic [DATA_WIDTH-1:0]          window_feeder_data_in,
  input  logic                           window_feeder_clr,
  input  logic                           weight_wr_en,
  input  logic [clog2(NUM_ELEMENTS)-1:0] weight_wr_addr,
  input  logic [DATA_WIDTH-1:0]          weight_wr_data,
  output logic                           weight_wr_ready,
  input  logic                           window_feeder_ready_out,
  output logic                           window_feeder_valid_out,
  output logic [DATA_WIDTH-1:0]          window_feeder_dataa_out,
  output logic [DATA_WIDTH-1:0]          window_feeder_datab_out,
  output logic                           window_feeder_last_out
);

  localparam int IDX_W  = clog2(NUM_ELEMENTS);
  localparam int FILL_W = clog2(NUM_ELEMENTS + 1);
  localparam int STR_W  = clog2(STRIDE + 1);

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_ELEMENTS - 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(NUM_ELEMENTS - 1);
  localparam logic [STR_W-1:0]  STR_LAST  = STR_W'(STRIDE - 1);

  window_feeder_state_t  state_r, state_s;
  logic [DATA_WIDTH-1:0] win_r [NUM_ELEMENTS];
  logic [DATA_WIDTH-1:0] win_s [NUM_ELEMENTS];
  logic [FILL_W-1:0]     fill_cnt_r, fill_cnt_s;
  logic [STR_W-1:0]      stride_cnt_r, stride_cnt_s;
  logic [IDX_W-1:0]      idx_r, idx_s;
  logic                  valid_r, valid_s;
  logic                  last_r, last_s;
  logic [DATA_WIDTH-1:0] dataa_r, dataa_s;
  logic [DATA_WIDTH-1:0] datab_r, datab_s;
  logic                  ready_in_r, ready_in_s;
  logic                  wr_ready_r, wr_ready_s;

  logic                  accept_s;
  logic                  handshake_s;
  logic                  enter_s;
  logic                  wr_en_s;
  logic [IDX_W-1:0]      rd_idx_s;
  logic [DATA_WIDTH-1:0] rd_data_s;

  assign accept_s    = ready_in_r && window_feeder_valid_in && !window_feeder_clr;
  assign handshake_s = valid_r && window_feeder_ready_out;
  assign wr_en_s     = weight_wr_en && wr_ready_r;

  // Weight index the output register will need after this edge: 0 on burst
  // start, idx+1 while advancing inside a burst.
  always_comb begin
    if ((state_r == STREAM) && handshake_s && (idx_r != IDX_LAST)) begin
      rd_idx_s = idx_r + IDX_W'(1);
    end else begin
      rd_idx_s = {IDX_W{1'b0}};
    end
  end

  weight_bank #(
    .DATA_WIDTH   (DATA_WIDTH),
    .NUM_ELEMENTS (NUM_ELEMENTS)
  ) u_weight_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en_s),
    .wr_addr (weight_wr_addr),
    .wr_data (weight_wr_data),
    .rd_idx  (rd_idx_s),
    .rd_data (rd_data_s)
  );

  // Next-state logic for window, counters, FSM and the registered beat.
  always_comb begin
    state_s      = state_r;
    win_s        = win_r;
    fill_cnt_s   = fill_cnt_r;
    stride_cnt_s = stride_cnt_r;
    idx_s        = idx_r;
    valid_s      = valid_r;
    last_s       = last_r;
    dataa_s      = dataa_r;
    datab_s      = datab_r;
    ready_in_s   = ready_in_r;
    wr_ready_s   = wr_ready_r;
    enter_s      = 1'b0;

    if (accept_s) begin
      for (int i = NUM_ELEMENTS - 1; i > 0; i--) begin
        win_s[i] = win_r[i-1];
      end
      win_s[0] = window_feeder_data_in;
    end else begin
      win_s = win_r;
    end

    if (window_feeder_clr) begin
      state_s      = FILL;
      fill_cnt_s   = {FILL_W{1'b0}};
      stride_cnt_s = {STR_W{1'b0}};
      idx_s        = {IDX_W{1'b0}};
      valid_s      = 1'b0;
      last_s       = 1'b0;
      ready_in_s   = 1'b1;
      wr_ready_s   = 1'b1;
    end else begin
      case (state_r)
        FILL: begin
          if (accept_s) begin
            fill_cnt_s = fill_cnt_r + FILL_W'(1);
            enter_s    = (fill_cnt_r == FILL_LAST);
          end else begin
            fill_cnt_s = fill_cnt_r;
          end
        end
        WAIT: begin
          if (accept_s) begin
            stride_cnt_s = stride_cnt_r + STR_W'(1);
            enter_s      = (stride_cnt_r == STR_LAST);
          end else begin
            stride_cnt_s = stride_cnt_r;
          end
        end
        STREAM: begin
          if (handshake_s && (idx_r == IDX_LAST)) begin
            state_s      = WAIT;
            stride_cnt_s = {STR_W{1'b0}};
            valid_s      = 1'b0;
            last_s       = 1'b0;
            ready_in_s   = 1'b1;
            wr_ready_s   = 1'b1;
          end else if (handshake_s) begin
            idx_s   = idx_r + IDX_W'(1);
            dataa_s = win_r[IDX_LAST - idx_s];
            datab_s = rd_data_s;
            last_s  = (idx_s == IDX_LAST);
          end else begin
            idx_s = idx_r;
          end
        end
        default: begin
          state_s    = FILL;
          fill_cnt_s = {FILL_W{1'b0}};
          valid_s    = 1'b0;
          last_s     = 1'b0;
          ready_in_s = 1'b1;
          wr_ready_s = 1'b1;
        end
      endcase

      if (enter_s) begin
        state_s    = STREAM;
        idx_s      = {IDX_W{1'b0}};
        valid_s    = 1'b1;
        last_s     = 1'b0;
        dataa_s    = win_s[NUM_ELEMENTS-1];
        datab_s    = rd_data_s;
        ready_in_s = 1'b0;
        wr_ready_s = 1'b0;
      end else begin
        state_s = state_s;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= FILL;
      for (int i = 0; i < NUM_ELEMENTS; i++) begin
        win_r[i] <= {DATA_WIDTH{1'b0}};
      end
      fill_cnt_r   <= {FILL_W{1'b0}};
      stride_cnt_r <= {STR_W{1'b0}};
      idx_r        <= {IDX_W{1'b0}};
      valid_r      <= 1'b0;
      last_r       <= 1'b0;
      dataa_r      <= {DATA_WIDTH{1'b0}};
      datab_r      <= {DATA_WIDTH{1'b0}};
      ready_in_r   <= 1'b1;
      wr_ready_r   <= 1'b1;
    end else begin
      state_r      <= state_s;
      win_r        <= win_s;
      fill_cnt_r   <= fill_cnt_s;
      stride_cnt_r <= stride_cnt_s;
      idx_r        <= idx_s;
      valid_r      <= valid_s;
      last_r       <= last_s;
      dataa_r      <= dataa_s;
      datab_r      <= datab_s;
      ready_in_r   <= ready_in_s;
      wr_ready_r   <= wr_ready_s;
    end
  end

  assign window_feeder_ready_in  = ready_in_r;
  assign weight_wr_ready         = wr_ready_r;
  assign window_feeder_valid_out = valid_r;
  assign window_feeder_last_out  = last_r;
  assign window_feeder_dataa_out = dataa_r;
  assign window_feeder_datab_out = datab_r;

endmodule

// File: tb/tb_window_feeder.sv
// Scoreboard bench for window_feeder: one instance with STRIDE=1, one with STRIDE=2.
module tb_window_feeder;

  localparam int DW = 12;
  localparam int N  = 5;
  localparam int AW = 3;

  typedef struct {
    int a;
    int b;
    bit last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          ready_in  [2];
  logic          valid_in  [2];
  logic [DW-1:0] data_in   [2];
  logic          clr       [2];
  logic          wr_en     [2];
  logic [AW-1:0] wr_addr   [2];
  logic [DW-1:0] wr_data   [2];
  logic          wr_ready  [2];
  logic          ready_out [2];
  logic          valid_out [2];
  logic [DW-1:0] dataa     [2];
  logic [DW-1:0] datab     [2];
  logic          last      [2];

  int    mwin    [2][N];
  int    mw      [2][N];
  int    mcnt    [2];
  bit    mfull   [2];
  int    mstride [2];
  beat_t sb_q    [2][$];
  int    res_q   [2][$];
  int    acc     [2];
  int    n_tests = 0;
  int    n_fail  = 0;

  always #5 clk = ~clk;

  window_feeder #(.DATA_WIDTH(DW), .NUM_ELEMENTS(N), .STRIDE(1)) dut_s1 (
    .clk                     (clk),
    .rst                     (rst),
    .window_feeder_ready_in  (ready_in[0]),
    .window_feeder_valid_in  (valid_in[0]),
    .window_feeder_data_in   (data_in[0]),
    .window_feeder_clr       (clr[0]),
    .weight_wr_en            (wr_en[0]),
    .weight_wr_addr          (wr_addr[0]),
    .weight_wr_data          (wr_data[0]),
    .weight_wr_ready         (wr_ready[0]),
    .window_feeder_ready_out (ready_out[0]),
    .window_feeder_valid_out (valid_out[0]),
    .window_feeder_dataa_out (dataa[0]),
    .window_feeder_datab_out (datab[0]),
    .window_feeder_last_out  (last[0])
  );

  window_feeder #(.DATA_WIDTH(DW), .NUM_ELEMENTS(N), .STRIDE(2)) dut_s2 (
    .clk                     (clk),
    .rst                     (rst),
    .window_feeder_ready_in  (ready_in[1]),
    .window_feeder_valid_in  (valid_in[1]),
    .window_feeder_data_in   (data_in[1]),
    .window_feeder_clr       (clr[1]),
    .weight_wr_en            (wr_en[1]),
    .weight_wr_addr          (wr_addr[1]),
    .weight_wr_data          (wr_data[1]),
    .weight_wr_ready         (wr_ready[1]),
    .window_feeder_ready_out (ready_out[1]),
    .window_feeder_valid_out (valid_out[1]),
    .window_feeder_dataa_out (dataa[1]),
    .window_feeder_datab_out (datab[1]),
    .window_feeder_last_out  (last[1])
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference window: emits a burst when the window first fills, then every STRIDE samples.
  task automatic model_accept(input int d, input int x);
    beat_t b;
    for (int i = N - 1; i > 0; i--) mwin[d][i] = mwin[d][i-1];
    mwin[d][0] = x;
    mcnt[d]++;
    if ((!mfull[d] && mcnt[d] == N) || (mfull[d] && mcnt[d] == mstride[d])) begin
      for (int i = 0; i < N; i++) begin
        b.a    = mwin[d][N-1-i];
        b.b    = mw[d][i];
        b.last = (i == N - 1);
        sb_q[d].push_back(b);
      end
      mfull[d] = 1'b1;
      mcnt[d]  = 0;
    end
  endtask

  task automatic model_flush(input int d, input bit clear_weights);
    sb_q[d].delete();
    mcnt[d]  = 0;
    mfull[d] = 1'b0;
    acc[d]   = 0;
    if (clear_weights) begin
      for (int i = 0; i < N; i++) mw[d][i] = 0;
    end
  endtask

  task automatic send_sample(input int d, input int x);
    int cyc;
    bit done;
    cyc  = 0;
    done = 1'b0;
    @(posedge clk); #1;
    valid_in[d] = 1'b1;
    data_in[d]  = x[DW-1:0];
    while (!done && cyc < 200) begin
      @(negedge clk);
      if (ready_in[d] && !rst) begin
        check_eq($sformatf("accept_after_burst_d%0d", d), sb_q[d].size(), 0);
        @(posedge clk); #1;
        done = 1'b1;
      end else begin
        cyc++;
      end
    end
    valid_in[d] = 1'b0;
    check_eq($sformatf("accept_timeout_d%0d", d), int'(done), 1);
    if (done) model_accept(d, x);
  endtask

  task automatic write_weight(input int d, input int addr, input int val, input bit exp_acc);
    @(posedge clk); #1;
    wr_en[d]   = 1'b1;
    wr_addr[d] = addr[AW-1:0];
    wr_data[d] = val[DW-1:0];
    @(negedge clk);
    check_eq($sformatf("wr_ready_d%0d", d), int'(wr_ready[d]), int'(exp_acc));
    @(posedge clk); #1;
    wr_en[d] = 1'b0;
    if (exp_acc && addr < N) mw[d][addr] = val;
  endtask

  task automatic pulse_clr(input int d);
    @(posedge clk); #1;
    clr[d] = 1'b1;
    @(posedge clk); #1;
    clr[d] = 1'b0;
    model_flush(d, 1'b0);
  endtask

  task automatic wait_drain(input int d);
    int cyc;
    cyc = 0;
    while ((sb_q[d].size() != 0 || valid_out[d]) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq($sformatf("drain_timeout_d%0d", d), int'(cyc < 200), 1);
    check_eq($sformatf("idle_valid_d%0d", d), int'(valid_out[d]), 0);
    check_eq($sformatf("idle_ready_in_d%0d", d), int'(ready_in[d]), 1);
  endtask

  task automatic check_results(input int d, input int e0, input int e1);
    check_eq($sformatf("result_count_d%0d", d), res_q[d].size(), 2);
    if (res_q[d].size() >= 2) begin
      check_eq($sformatf("result0_d%0d", d), res_q[d][0], e0);
      check_eq($sformatf("result1_d%0d", d), res_q[d][1], e1);
    end
    res_q[d].delete();
  endtask

  // Output monitor: pops the scoreboard on every handshake and folds a dot product.
  always @(negedge clk) begin
    beat_t e;
    for (int d = 0; d < 2; d++) begin
      if (!rst && valid_out[d] && ready_out[d]) begin
        check_eq($sformatf("beat_expected_d%0d", d), int'(sb_q[d].size() > 0), 1);
        if (sb_q[d].size() > 0) begin
          e = sb_q[d].pop_front();
          check_eq($sformatf("dataa_d%0d", d), int'(dataa[d]), e.a);
          check_eq($sformatf("datab_d%0d", d), int'(datab[d]), e.b);
          check_eq($sformatf("last_d%0d", d), int'(last[d]), int'(e.last));
          acc[d] = acc[d] + int'(dataa[d]) * int'(datab[d]);
          if (last[d]) begin
            res_q[d].push_back(acc[d]);
            acc[d] = 0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst        = 1'b1;
    mstride[0] = 1;
    mstride[1] = 2;
    for (int d = 0; d < 2; d++) begin
      valid_in[d]  = 1'b0;
      data_in[d]   = '0;
      clr[d]       = 1'b0;
      wr_en[d]     = 1'b0;
      wr_addr[d]   = '0;
      wr_data[d]   = '0;
      ready_out[d] = 1'b1;
      for (int i = 0; i < N; i++) mwin[d][i] = 0;
      model_flush(d, 1'b1);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("rst_ready_in_d%0d", d), int'(ready_in[d]), 1);
      check_eq($sformatf("rst_valid_d%0d", d), int'(valid_out[d]), 0);
      check_eq($sformatf("rst_last_d%0d", d), int'(last[d]), 0);
      check_eq($sformatf("rst_dataa_d%0d", d), int'(dataa[d]), 0);
      check_eq($sformatf("rst_datab_d%0d", d), int'(datab[d]), 0);
      check_eq($sformatf("rst_wr_ready_d%0d", d), int'(wr_ready[d]), 1);
    end

    // STRIDE=1: weights 1..5, an ignored out-of-range write, then a stalled burst.
    for (int i = 0; i < N; i++) write_weight(0, i, i + 1, 1'b1);
    write_weight(0, 7, 99, 1'b1);
    for (int i = 1; i <= 4; i++) send_sample(0, i * 10);
    send_sample(0, 50);
    @(posedge clk); #1;
    ready_out[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("stall_valid", int'(valid_out[0]), 1);
      check_eq("stall_dataa", int'(dataa[0]), 20);
      check_eq("stall_datab", int'(datab[0]), 2);
      check_eq("stall_last", int'(last[0]), 0);
      check_eq("stall_ready_in", int'(ready_in[0]), 0);
    end
    @(posedge clk); #1;
    ready_out[0] = 1'b1;
    send_sample(0, 60);
    wait_drain(0);
    check_results(0, 550, 700);

    // STRIDE=2: a weight write during STREAM is dropped; sample 60 alone makes no burst.
    for (int i = 0; i < N; i++) write_weight(1, i, i + 1, 1'b1);
    for (int i = 1; i <= 4; i++) send_sample(1, i * 10);
    send_sample(1, 50);
    write_weight(1, 0, 9, 1'b0);
    wait_drain(1);
    send_sample(1, 60);
    repeat (4) @(negedge clk);
    check_eq("stride_no_burst", int'(valid_out[1]), 0);
    send_sample(1, 70);
    wait_drain(1);
    check_results(1, 550, 850);

    // Reset during beat 3 of a burst.
    send_sample(0, 70);
    cyc = 0;
    while (sb_q[0].size() > 2 && cyc < 50) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    check_eq("mid_burst_reached", int'(valid_out[0]), 1);
    rst = 1'b1;
    #1;
    check_eq("rst_mid_valid", int'(valid_out[0]), 0);
    check_eq("rst_mid_ready_in", int'(ready_in[0]), 1);
    for (int d = 0; d < 2; d++) begin
      model_flush(d, 1'b1);
      res_q[d].delete();
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) send_sample(0, i);
    repeat (2) @(negedge clk);
    check_eq("post_rst_no_burst", int'(valid_out[0]), 0);
    send_sample(0, 5);
    check_eq("post_rst_burst_start", int'(valid_out[0]), 1);
    wait_drain(0);

    // clr in WAIT: window restarts, weights survive.
    for (int i = 0; i < N; i++) write_weight(0, i, i + 1, 1'b1);
    pulse_clr(0);
    check_eq("clr_ready_in", int'(ready_in[0]), 1);
    for (int i = 6; i <= 9; i++) send_sample(0, i);
    repeat (2) @(negedge clk);
    check_eq("post_clr_no_burst", int'(valid_out[0]), 0);
    send_sample(0, 10);
    wait_drain(0);
    check_results(0, 0, 130);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
